mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//   Moore-style control FSM for the multicycle MIPS datapath. Sequences the PC, IR, A/B, ALUOut
//   and MDR registers, the register file, ALU and unified memory through fetch/decode/execute/
//   writeback. Adds memory wait-state handshake with a bounded-wait watchdog. One instance per core.
// PARAMETERS
//   MAX_WAIT  15  max cycles a memory access may stall (mem_ready low) before watchdog trips; >=1
// PORTS
//   clk          in   1  single clock; all state changes on posedge clk
//   reset        in   1  synchronous, active-high; sampled on posedge clk
//   opcode       in   6  IR[31:26], valid from DECODE onward
//   zero         in   1  ALU zero flag (BRANCH state)
//   mem_ready    in   1  memory has completed current read/write this cycle
//   pc_en        out  1  PC load enable (pc_write | branch & zero)
//   ir_write     out  1  IR load enable
//   mem_read     out  1  memory read request
//   mem_write    out  1  memory write request
//   iord         out  1  0: address=PC, 1: address=ALUOut
//   reg_write    out  1  register file write enable
//   reg_dst      out  1  0: rt, 1: rd
//   mem_to_reg   out  1  0: ALUOut, 1: MDR
//   alu_src_a    out  1  0: PC, 1: A
//   alu_src_b    out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_op       out  2  00 add, 01 sub, 10 funct-decoded
//   pc_src       out  2  00 ALU result, 01 ALUOut, 10 jump target
//   illegal_op   out  1  one-cycle pulse: unknown opcode decoded
//   mem_timeout  out  1  sticky: watchdog tripped, FSM halted
//   state        out  4  current state encoding (debug/verification)
// BEHAVIOUR
//   Reset: state=FETCH(0), wait counter=0, mem_timeout=0, illegal_op=0; all enables low except those
//   FETCH drives (mem_read=1, alu_src_b=01); reset wins over every other event, incl. mid-stall.
//   Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
//   States/outputs (unlisted outputs 0):
//   0 FETCH : mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write and pc_en
//             asserted only in the cycle mem_ready=1 -> DECODE; else stay.
//   1 DECODE: alu_src_b=11 (branch target into ALUOut). R->EXEC, LW/SW->MEMADR, BEQ->BRANCH,
//             J->JUMP, ADDI->ADDIEX, other -> illegal_op=1 for this cycle, ->FETCH.
//   2 MEMADR: alu_src_a=1, alu_src_b=10. LW->MEMRD, SW->MEMWR.
//   3 MEMRD : mem_read, iord=1; mem_ready ->MEMWB, else stay.
//   4 MEMWB : reg_write, reg_dst=0, mem_to_reg=1 ->FETCH.
//   5 MEMWR : mem_write, iord=1; mem_ready ->FETCH, else stay.
//   6 EXEC  : alu_src_a=1, alu_src_b=00, alu_op=10 ->RTWB.
//   7 RTWB  : reg_write, reg_dst=1, mem_to_reg=0 ->FETCH.
//   8 BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero ->FETCH.
//   9 JUMP  : pc_src=10, pc_en=1 ->FETCH.
//   10 ADDIEX: alu_src_a=1, alu_src_b=10 ->ADDIWB.  11 ADDIWB: reg_write, reg_dst=0 ->FETCH.
//   12 HALT : all enables 0; stay until reset.
//   Latency (zero-wait): LW 5, SW/R/ADDI 4, BEQ/J 3 cycles. Each stall cycle adds 1.
//   Wait counter: in FETCH/MEMRD/MEMWR increments each cycle mem_ready=0, cleared on state exit.
//   If mem_ready=0 while counter==MAX_WAIT-1 (i.e. MAX_WAIT stall cycles done): -> HALT,
//   mem_timeout=1 next cycle; no write enable (ir_write, pc_en, reg_write) ever fires for that access.
//   mem_ready=1 on the final permitted cycle completes normally. mem_ready ignored outside 0/3/5.
//   Request signals stay asserted, address stable, for entire stall.
//   Codes 13-15 unreachable; if entered, next state FETCH.
// TESTING
//   1 reset, mem_ready=1, LW: states 0,1,2,3,4,0; one ir_write, one reg_write w/ mem_to_reg=1.
//   2 SW with mem_ready low 2 cycles in MEMWR: mem_write high 3 cycles, then FETCH; no reg_write.
//   3 BEQ zero=1 -> pc_en=1, pc_src=01 in state 8; zero=0 -> pc_en=0; both return to FETCH.
//   4 opcode 111111: illegal_op pulses exactly 1 cycle in DECODE, next state FETCH, no writes.
//   5 MAX_WAIT=3, mem_ready stuck 0 in FETCH: 3 stall cycles, then state=12, mem_timeout=1 held;
//     mem_ready=1 at 3rd stall cycle instead -> normal DECODE, mem_timeout=0.
//   6 reset asserted in MEMRD mid-stall: next cycle state=0, counter=0, mem_timeout=0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS datapath, with memory wait-state
// handshake and a bounded-wait watchdog that halts the core when memory stalls too long.
module mips_multicycle_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    state_t        cur_state, nxt_state;
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          timeout_flag, timeout_nxt;
    logic          wait_done;
    logic          stall_halt;
    logic [CW-1:0] wait_cnt_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state    <= S_FETCH;
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            wait_cnt     <= wait_cnt_nxt;
            timeout_flag <= timeout_nxt;
        end
    end

    assign wait_done    = (wait_cnt == CW'(MAX_WAIT - 1));
    assign stall_halt   = !mem_ready && wait_done;
    assign wait_cnt_inc = wait_cnt + CW'(1);
    assign mem_timeout  = timeout_flag;
    assign state        = cur_state;

    always_comb begin
        nxt_state    = cur_state;
        wait_cnt_nxt = '0;
        timeout_nxt  = timeout_flag;
        pc_en        = 1'b0;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        iord         = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        pc_src       = 2'b00;
        illegal_op   = 1'b0;

        // Memory states share one stall rule: count while not ready, halt on the last permitted cycle.
        if ((cur_state == S_FETCH || cur_state == S_MEMRD || cur_state == S_MEMWR) && !mem_ready) begin
            if (stall_halt) begin
                nxt_state   = S_HALT;
                timeout_nxt = 1'b1;
            end else begin
                wait_cnt_nxt = wait_cnt_inc;
            end
        end

        case (cur_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_R:         nxt_state = S_EXEC;
                    OP_LW, OP_SW: nxt_state = S_MEMADR;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI:      nxt_state = S_ADDIEX;
                    default: begin
                        illegal_op = 1'b1;
                        nxt_state  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) nxt_state = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                nxt_state  = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) nxt_state = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                nxt_state = S_RTWB;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                pc_en     = zero;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src    = 2'b10;
                pc_en     = 1'b1;
                nxt_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                nxt_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                nxt_state = S_FETCH;
            end
            S_HALT: nxt_state = S_HALT;
            default: nxt_state = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for mips_multicycle_ctrl (MAX_WAIT=3); expected values
// are queued when each vector is driven and popped when the outputs are sampled.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    mips_multicycle_ctrl #(.MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    // we bits: {pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op, mem_timeout}
    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       rdy;
        logic [3:0] st;   // 4'hF: state not checked
        logic [6:0] we;
    } vec_t;

    typedef struct {
        logic [3:0] st;
        logic [6:0] we;
        logic [9:0] mux;
    } exp_t;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;
    localparam logic [6:0] NONE = 7'b0000000, FIN = 7'b1110000, RD = 7'b0010000;
    localparam logic [6:0] WR = 7'b0001000, RW = 7'b0000100, PCW = 7'b1000000;
    localparam logic [6:0] ILL = 7'b0000010, TMO = 7'b0000001;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src} from the state table
    function automatic logic [9:0] mux_for(input logic [3:0] s);
        case (s)
            4'd0:    return 10'b0000_01_00_00;
            4'd1:    return 10'b0000_11_00_00;
            4'd2:    return 10'b0001_10_00_00;
            4'd3:    return 10'b1000_00_00_00;
            4'd4:    return 10'b0010_00_00_00;
            4'd5:    return 10'b1000_00_00_00;
            4'd6:    return 10'b0001_00_10_00;
            4'd7:    return 10'b0100_00_00_00;
            4'd8:    return 10'b0001_00_01_01;
            4'd9:    return 10'b0000_00_00_10;
            4'd10:   return 10'b0001_10_00_00;
            default: return 10'b0000_00_00_00;
        endcase
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                       input logic [3:0] st, input logic [6:0] we);
        vec_t v;
        v.rst = rst; v.op = op; v.z = z; v.rdy = rdy; v.st = st; v.we = we;
        vecs.push_back(v);
    endtask

    initial begin
        logic [6:0] got_we;
        logic [9:0] got_mux;
        exp_t       e;

        // 1: LW zero-wait
        add(1, R,    0, 1, 4'hF, NONE);
        add(0, LW,   0, 1, 0, FIN);
        add(0, LW,   0, 1, 1, NONE);
        add(0, LW,   0, 1, 2, NONE);
        add(0, LW,   0, 1, 3, RD);
        add(0, LW,   0, 1, 4, RW);
        // 2: SW with two stall cycles in MEMWR
        add(0, SW,   0, 1, 0, FIN);
        add(0, SW,   0, 1, 1, NONE);
        add(0, SW,   0, 1, 2, NONE);
        add(0, SW,   0, 0, 5, WR);
        add(0, SW,   0, 0, 5, WR);
        add(0, SW,   0, 1, 5, WR);
        // 3: BEQ taken, then not taken
        add(0, BEQ,  1, 1, 0, FIN);
        add(0, BEQ,  1, 1, 1, NONE);
        add(0, BEQ,  1, 1, 8, PCW);
        add(0, BEQ,  0, 1, 0, FIN);
        add(0, BEQ,  0, 1, 1, NONE);
        add(0, BEQ,  0, 1, 8, NONE);
        // J, R-type, ADDI
        add(0, J,    0, 1, 0, FIN);
        add(0, J,    0, 1, 1, NONE);
        add(0, J,    0, 1, 9, PCW);
        add(0, R,    0, 1, 0, FIN);
        add(0, R,    0, 1, 1, NONE);
        add(0, R,    0, 1, 6, NONE);
        add(0, R,    0, 1, 7, RW);
        add(0, ADDI, 0, 1, 0, FIN);
        add(0, ADDI, 0, 1, 1, NONE);
        add(0, ADDI, 0, 1, 10, NONE);
        add(0, ADDI, 0, 1, 11, RW);
        // 4: illegal opcode
        add(0, BAD,  0, 1, 0, FIN);
        add(0, BAD,  0, 1, 1, ILL);
        // 5b: ready arrives on the final permitted stall cycle
        add(0, R,    0, 0, 0, RD);
        add(0, R,    0, 0, 0, RD);
        add(0, R,    0, 1, 0, FIN);
        add(0, R,    0, 1, 1, NONE);
        add(0, R,    0, 1, 6, NONE);
        add(0, R,    0, 1, 7, RW);
        // 6: reset mid-stall in MEMRD clears the wait counter
        add(0, LW,   0, 1, 0, FIN);
        add(0, LW,   0, 1, 1, NONE);
        add(0, LW,   0, 1, 2, NONE);
        add(0, LW,   0, 0, 3, RD);
        add(1, LW,   0, 0, 3, RD);
        add(0, J,    0, 0, 0, RD);
        add(0, J,    0, 0, 0, RD);
        add(0, J,    0, 1, 0, FIN);
        add(0, J,    0, 1, 1, NONE);
        add(0, J,    0, 1, 9, PCW);
        // 5a: FETCH stuck -> HALT with sticky timeout, cleared only by reset
        add(0, LW,   0, 0, 0, RD);
        add(0, LW,   0, 0, 0, RD);
        add(0, LW,   0, 0, 0, RD);
        add(0, LW,   0, 1, 12, TMO);
        add(0, LW,   0, 1, 12, TMO);
        add(1, LW,   0, 1, 12, TMO);
        add(0, LW,   0, 1, 0, FIN);

        reset = 1'b1; opcode = R; zero = 1'b0; mem_ready = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
            e.st = vecs[i].st; e.we = vecs[i].we; e.mux = mux_for(vecs[i].st);
            exp_q.push_back(e);
            #1;
            e = exp_q.pop_front();
            if (e.st != 4'hF) begin
                got_we  = {pc_en, ir_write, mem_read, mem_write, reg_write, illegal_op, mem_timeout};
                got_mux = {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src};
                checks++;
                if (state !== e.st) begin
                    failures++;
                    $display("FAIL state vec=%0d got=%0d want=%0d", i, state, e.st);
                end
                checks++;
                if (got_we !== e.we) begin
                    failures++;
                    $display("FAIL enables vec=%0d got=%b want=%b", i, got_we, e.we);
                end
                checks++;
                if (got_mux !== e.mux) begin
                    failures++;
                    $display("FAIL muxes vec=%0d got=%b want=%b", i, got_mux, e.mux);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
